mod3_check_scheduler: RTL and testbench

//  Shares one bit-serial mod-3 remainder engine between NREQ requesters. Each requester offers a WIDTH-bit word.
//  The scheduler grants requesters round-robin and latches the granted word. It shifts the word MSB-first through the

---
 rtl/mod3_pkg.sv | 26 ++
 rtl/mod3_serial_fsm.sv | 28 ++
 rtl/mod3_check_scheduler.sv | 150 +++++++++++++++
 tb/tb_mod3_check_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod3_pkg.sv
// Shared types and the mod-3 step function for the mod3_check_scheduler slice.
package mod3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        RESP  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        R0 = 2'b00,
        R1 = 2'b01,
        R2 = 2'b10
    } rem_t;

    // Remainder after appending one bit on the LSB side: (2*rem + b) mod 3.
    function automatic rem_t next_rem(input rem_t rem, input logic b);
        case (rem)
            R0:      return b ? R1 : R0;
            R1:      return b ? R0 : R2;
            R2:      return b ? R2 : R1;
            default: return R0;
        endcase
    endfunction

endpackage

// File: rtl/mod3_serial_fsm.sv
// Bit-serial mod-3 remainder engine, fed MSB-first. clr wins over bit_en.
module mod3_serial_fsm
    import mod3_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [1:0] rem
);

    rem_t r_rem;

    // Remainder state: cleared at job start, stepped once per shifted bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem <= R0;
        end else if (clr) begin
            r_rem <= R0;
        end else if (bit_en) begin
            r_rem <= next_rem(r_rem, bit_in);
        end
    end

    assign rem = r_rem;

endmodule

// File: rtl/mod3_check_scheduler.sv
// Round-robin scheduler sharing one mod3_serial_fsm engine among NREQ requesters.
// Optional build macro MOD3_PERF_CNT_EN adds saturating cnt_done/cnt_div3 outputs.
module mod3_check_scheduler
    import mod3_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  WIDTH = 8,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [1:0]            rsp_rem,
    output logic                  rsp_div3,
`ifdef MOD3_PERF_CNT_EN
    output logic [15:0]           cnt_done,
    output logic [15:0]           cnt_div3,
`endif
    output logic                  busy
);

    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [WIDTH-1:0] r_shift;
    logic [CNTW-1:0]  r_cnt;
    logic [IDW-1:0]   r_id;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [1:0]       r_rsp_rem;
    logic             r_rsp_div3;

    logic             w_any;
    logic [IDW-1:0]   w_gnt;
    logic [IDW-1:0]   w_idx;
    logic             w_accept;
    logic [1:0]       w_rem;
    rem_t             w_last_rem;

    // Arbiter: first valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IDW'((32'(r_rr_ptr) + k) % NREQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    // Gated by reset_n so req_ready reads 0 while reset is held.
    assign req_ready = (reset_n && (r_state == IDLE) && w_any) ? (NREQ'(1) << w_gnt) : '0;
    assign w_accept  = |(req_valid & req_ready);

    // Engine output is one bit behind; fold in the final bit to register the result.
    assign w_last_rem = next_rem(rem_t'(w_rem), r_shift[WIDTH-1]);

    mod3_serial_fsm u_engine (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_accept),
        .bit_en  (r_state == SHIFT),
        .bit_in  (r_shift[WIDTH-1]),
        .rem     (w_rem)
    );

    // Scheduler FSM: accept, shift WIDTH bits, hold response until taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_rem   <= '0;
            r_rsp_div3  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift  <= req_data[w_gnt*WIDTH +: WIDTH];
                        r_id     <= w_gnt;
                        r_cnt    <= CNTW'(WIDTH - 1);
                        r_rr_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_rsp_rem   <= w_last_rem;
                        r_rsp_div3  <= (w_last_rem == R0);
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_rem   = r_rsp_rem;
    assign rsp_div3  = r_rsp_div3;
    assign busy      = (r_state != IDLE);

`ifdef MOD3_PERF_CNT_EN
    logic [15:0] r_cnt_done;
    logic [15:0] r_cnt_div3;

    // Saturating counters of completed responses and divisible-by-3 responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_done <= '0;
            r_cnt_div3 <= '0;
        end else if (r_rsp_valid && rsp_ready) begin
            if (r_cnt_done != '1) begin
                r_cnt_done <= r_cnt_done + 1'b1;
            end
            if (r_rsp_div3 && (r_cnt_div3 != '1)) begin
                r_cnt_div3 <= r_cnt_div3 + 1'b1;
            end
        end
    end

    assign cnt_done = r_cnt_done;
    assign cnt_div3 = r_cnt_div3;
`endif

endmodule

// File: tb/tb_mod3_check_scheduler.sv
// Directed self-checking bench for mod3_check_scheduler (NREQ=4, WIDTH=8).
module tb_mod3_check_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [1:0]            rsp_rem;
    logic                  rsp_div3;
    logic                  busy;
`ifdef MOD3_PERF_CNT_EN
    logic [15:0]           cnt_done;
    logic [15:0]           cnt_div3;
`endif

    int n_checks;
    int n_fail;

    mod3_check_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_rem   (rsp_rem),
        .rsp_div3  (rsp_div3),
`ifdef MOD3_PERF_CNT_EN
        .cnt_done  (cnt_done),
        .cnt_div3  (cnt_div3),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset;
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drive one job on requester id, wait (bounded) for the response, then consume it.
    task automatic send_word(input int id, input logic [7:0] d,
                             output logic [NREQ-1:0] rdy, output int lat,
                             output logic [IDW-1:0] gid, output logic [1:0] grem,
                             output logic gdiv);
        @(negedge clk);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        req_data[id*WIDTH +: WIDTH] = d;
        #1 rdy = req_ready;
        @(posedge clk);
        #1 req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        gid  = rsp_id;
        grem = rsp_rem;
        gdiv = rsp_div3;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_state;
        reset_n   = 1'b0;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b0;
        #12;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_rem, rsp_div3, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b valid=%b id=%0d rem=%0d div3=%b busy=%b, expected all 0",
                     req_ready, rsp_valid, rsp_id, rsp_rem, rsp_div3, busy);
        end
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_words;
        int             req_id  [5] = '{1, 0, 2, 3, 1};
        logic [7:0]     word    [5] = '{8'd9, 8'd10, 8'd11, 8'hFF, 8'd0};
        logic [1:0]     exp_rem [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
        logic [NREQ-1:0] rdy;
        int             lat;
        logic [IDW-1:0] gid;
        logic [1:0]     grem;
        logic           gdiv;
        for (int i = 0; i < 5; i++) begin
            send_word(req_id[i], word[i], rdy, lat, gid, grem, gdiv);
            n_checks++;
            if (rdy !== (4'b0001 << req_id[i])) begin
                n_fail++;
                $display("FAIL word%0d_ready: got %b expected %b", i, rdy, 4'b0001 << req_id[i]);
            end
            n_checks++;
            if (lat !== WIDTH) begin
                n_fail++;
                $display("FAIL word%0d_latency: got %0d edges expected %0d", i, lat, WIDTH);
            end
            n_checks++;
            if (gid !== IDW'(req_id[i]) || grem !== exp_rem[i] || gdiv !== (exp_rem[i] == 2'd0)) begin
                n_fail++;
                $display("FAIL word%0d_result (data %0d): got id=%0d rem=%0d div3=%b expected id=%0d rem=%0d div3=%b",
                         i, word[i], gid, grem, gdiv, req_id[i], exp_rem[i], exp_rem[i] == 2'd0);
            end
            n_checks++;
            if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL word%0d_release: got busy=%b valid=%b expected 0 0", i, busy, rsp_valid);
            end
        end
    endtask

    task automatic test_reset_mid_shift;
        int wait_cyc;
        @(negedge clk);
        req_valid    = '0;
        req_valid[2] = 1'b1;
        req_data[2*WIDTH +: WIDTH] = 8'd11;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = '1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_rem, rsp_div3, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_shift: got ready=%b valid=%b id=%0d rem=%0d div3=%b busy=%b, expected all 0",
                     req_ready, rsp_valid, rsp_id, rsp_rem, rsp_div3, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_regrant: got ready=%b expected 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_cyc = 0;
        while (!rsp_valid && wait_cyc < 40) begin
            @(posedge clk);
            #1 wait_cyc++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_regrant_rsp: got valid=%b id=%0d expected 1 0", rsp_valid, rsp_id);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_stall;
        logic [IDW-1:0] s_id;
        logic [1:0]     s_rem;
        logic           s_div;
        int             wait_cyc;
        @(negedge clk);
        req_valid    = '0;
        req_valid[3] = 1'b1;
        req_data[3*WIDTH +: WIDTH] = 8'd10;
        @(posedge clk);
        #1 req_valid = 4'b0001;
        wait_cyc = 0;
        while (!rsp_valid && wait_cyc < 40) begin
            @(posedge clk);
            #1 wait_cyc++;
        end
        s_id  = rsp_id;
        s_rem = rsp_rem;
        s_div = rsp_div3;
        n_checks++;
        if (rsp_valid !== 1'b1 || s_id !== 2'd3 || s_rem !== 2'd1 || s_div !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_first: got valid=%b id=%0d rem=%0d div3=%b expected 1 3 1 0",
                     rsp_valid, s_id, s_rem, s_div);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== s_id || rsp_rem !== s_rem || rsp_div3 !== s_div
                || req_ready !== 4'b0000 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got valid=%b id=%0d rem=%0d div3=%b ready=%b busy=%b expected 1 %0d %0d %b 0000 1",
                         c, rsp_valid, rsp_id, rsp_rem, rsp_div3, req_ready, busy, s_id, s_rem, s_div);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got busy=%b valid=%b expected 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_round_robin;
        int         gid    [5];
        int         gtime  [5];
        int         exp_id [5] = '{0, 1, 2, 3, 0};
        logic [1:0] exp_rem[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        int         n;
        int         cyc;
        apply_reset();
        req_data  = {8'hFF, 8'd11, 8'd10, 8'd9};
        rsp_ready = 1'b1;
        req_valid = '1;
        n   = 0;
        cyc = 0;
        while (n < 5 && cyc < 200) begin
            #1;
            if (req_ready !== 4'b0000) begin
                for (int b = 0; b < NREQ; b++) begin
                    if (req_ready[b]) gid[n] = b;
                end
                gtime[n] = cyc;
                n++;
            end
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (rsp_rem !== exp_rem[rsp_id] || rsp_div3 !== (exp_rem[rsp_id] == 2'd0)) begin
                    n_fail++;
                    $display("FAIL rr_result id%0d: got rem=%0d div3=%b expected rem=%0d",
                             rsp_id, rsp_rem, rsp_div3, exp_rem[rsp_id]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        n_checks++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants expected 5", n);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (gid[i] !== exp_id[i]) begin
                    n_fail++;
                    $display("FAIL rr_order%0d: got req%0d expected req%0d", i, gid[i], exp_id[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (gtime[i+1] - gtime[i] !== WIDTH + 2) begin
                    n_fail++;
                    $display("FAIL rr_spacing%0d: got %0d cycles expected %0d",
                             i, gtime[i+1] - gtime[i], WIDTH + 2);
                end
            end
        end
        cyc = 0;
        while (busy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_drain: got busy=%b expected 0", busy);
        end
    endtask

`ifdef MOD3_PERF_CNT_EN
    task automatic test_perf_cnt;
        logic [NREQ-1:0] rdy;
        int              lat;
        logic [IDW-1:0]  gid;
        logic [1:0]      grem;
        logic            gdiv;
        logic [7:0]      w;
        int              exp_div;
        apply_reset();
        exp_div = 0;
        for (int i = 0; i < 300; i++) begin
            w = 8'($urandom_range(0, 255));
            if (w % 3 == 0) exp_div++;
            send_word(i % NREQ, w, rdy, lat, gid, grem, gdiv);
        end
        n_checks++;
        if (cnt_done !== 16'd300 || cnt_div3 !== 16'(exp_div)) begin
            n_fail++;
            $display("FAIL perf_cnt: got done=%0d div3=%0d expected done=300 div3=%0d",
                     cnt_done, cnt_div3, exp_div);
        end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        reset_n   = 1'b0;
        test_reset_state();
        test_words();
        test_reset_mid_shift();
        test_stall();
        test_round_robin();
`ifdef MOD3_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
